// File: rtl/byte_bank_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// byte_bank_sequencer : 8x8 register bank plus dwell-timed mux select scanner
// Optional macro SCAN_SKIP_ZERO_EN: scan visits only nonzero bank entries.
// Revision: 1.0 - initial release
// ============================================================================
module byte_bank_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  scan_start,
  input  logic                  scan_stop,
  input  logic                  loop,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [63:0]           bank_flat,
  output logic [2:0]            sel,
  output logic                  step_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            bank_q [8];
  logic [7:0]            bank_d [8];
  logic [2:0]            sel_q, sel_d;
  logic                  step_valid_q, step_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;

  logic [7:0] visit;
  logic [7:0] above;
  logic [2:0] first_idx, next_idx;
  logic       first_vld, next_vld;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // Candidate entries for the scan, judged on the bank as it stands before this edge's write.
`ifdef SCAN_SKIP_ZERO_EN
  always_comb begin
    visit = 8'h00;
    for (int i = 0; i < 8; i++) visit[i] = |bank_q[i];
  end
`else
  assign visit = 8'hFF;
`endif

  assign above     = visit & (8'hFE << sel_q);
  assign first_vld = |visit;
  assign next_vld  = |above;
  assign first_idx = lowest_set(visit);
  assign next_idx  = lowest_set(above);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    step_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    for (int i = 0; i < 8; i++) bank_d[i] = bank_q[i];
    if (wr_en) bank_d[wr_addr] = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (scan_start && !scan_stop) begin
          pre_d = prescale;
          cnt_d = prescale;
          if (first_vld) begin
            state_d      = ST_SCAN;
            sel_d        = first_idx;
            step_valid_d = 1'b1;
            busy_d       = 1'b1;
          end else begin
            state_d = ST_DONE;
            sel_d   = 3'd0;
            done_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (scan_stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (next_vld) begin
          sel_d        = next_idx;
          cnt_d        = pre_q;
          step_valid_d = 1'b1;
        end else if (loop && first_vld) begin
          sel_d        = first_idx;
          cnt_d        = pre_q;
          step_valid_d = 1'b1;
          done_d       = 1'b1;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      pre_q        <= '0;
      for (int i = 0; i < 8; i++) bank_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      for (int i = 0; i < 8; i++) bank_q[i] <= bank_d[i];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_flat
    assign bank_flat[8*g +: 8] = bank_q[g];
  end

  assign sel        = sel_q;
  assign step_valid = step_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_bank_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_byte_bank_sequencer : directed plus randomized bench with an index-level
// reference model of the scan. Revision: 1.0 - initial release
// ============================================================================
module tb_byte_bank_sequencer;

`ifdef SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        scan_start = 1'b0;
  logic        scan_stop = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic [63:0] bank_flat;
  logic [2:0]  sel;
  logic        step_valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 idle, 1 scanning, 2 done
  int       m_mode;
  int       m_idx;
  int       m_held;
  int       m_dwell;
  bit       m_sv;
  bit       m_done;
  bit [7:0] m_bank [8];

  byte_bank_sequencer #(.PRESCALE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scan_start(scan_start), .scan_stop(scan_stop), .loop(loop), .prescale(prescale),
    .bank_flat(bank_flat), .sel(sel), .step_valid(step_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_visit(input int after);
    for (int i = after + 1; i < 8; i++) begin
      if (!SKIP || m_bank[i] != 8'h00) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_held = 0; m_dwell = 1; m_sv = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
  endtask

  task automatic model_edge();
    int n;
    m_sv = 0;
    m_done = 0;
    case (m_mode)
      0: if (scan_start && !scan_stop) begin
        m_dwell = int'(prescale) + 1;
        n = next_visit(-1);
        if (n < 0) begin m_mode = 2; m_done = 1; m_idx = 0; end
        else begin m_mode = 1; m_idx = n; m_held = 1; m_sv = 1; end
      end
      1: if (scan_stop) m_mode = 0;
        else if (m_held < m_dwell) m_held++;
        else begin
          n = next_visit(m_idx);
          if (n >= 0) begin m_idx = n; m_held = 1; m_sv = 1; end
          else if (loop) begin
            n = next_visit(-1);
            m_done = 1;
            if (n >= 0) begin m_idx = n; m_held = 1; m_sv = 1; end
            else m_mode = 2;
          end else begin m_mode = 2; m_done = 1; end
        end
      default: m_mode = 0;
    endcase
    if (wr_en) m_bank[wr_addr] = wr_data;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] flat;
    for (int i = 0; i < 8; i++) flat[8*i +: 8] = m_bank[i];
    check_eq({tag, ".sel"}, 64'(sel), 64'(m_idx[2:0]));
    check_eq({tag, ".step_valid"}, 64'(step_valid), 64'(m_sv));
    check_eq({tag, ".busy"}, 64'(busy), 64'(m_mode == 1));
    check_eq({tag, ".done"}, 64'(done), 64'(m_done));
    check_eq({tag, ".bank_flat"}, bank_flat, flat);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // called at a falling edge; asserts reset between clock edges
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; scan_start = 1'b0; scan_stop = 1'b0;
  endtask

  task automatic wait_idx(input int idx, input int budget, input string tag);
    int k;
    k = 0;
    while (!(m_mode == 1 && m_idx == idx) && k < budget) begin
      tick(tag);
      k++;
    end
    if (k >= budget) check_eq({tag, ".timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int sv_cnt, done_cnt, busy_cnt;
    int seq_q[$];

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    tick("post_reset");

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h10 + i);
      tick("fill");
    end
    idle_inputs();
    tick("fill_idle");
    check_eq("bank_pattern", bank_flat, 64'h1716151413121110);

    // single pass, dwell 3
    prescale = 8'd2; loop = 1'b0; scan_start = 1'b1;
    sv_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick("pass");
      scan_start = 1'b0;
      sv_cnt += int'(step_valid);
      done_cnt += int'(done);
    end
    check_eq("pass_steps", 64'(sv_cnt), 64'd8);
    check_eq("pass_done", 64'(done_cnt), 64'd1);
    check_eq("pass_sel_end", 64'(sel), 64'd7);

    // continuous scan every cycle, stopped at index 4
    prescale = 8'd0; loop = 1'b1; scan_start = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick("loop");
      scan_start = 1'b0;
      done_cnt += int'(done && step_valid && sel == 3'd0);
    end
    check_eq("loop_wrap_done", 64'(done_cnt), 64'd1);
    wait_idx(4, 20, "loop_wait4");
    scan_stop = 1'b1;
    tick("stop");
    scan_stop = 1'b0;
    check_eq("stop_sel", 64'(sel), 64'd4);
    check_eq("stop_busy", 64'(busy), 64'd0);
    tick("stop_idle");

    // write the selected entry mid-scan, then reset at index 5
    prescale = 8'd4; loop = 1'b0; scan_start = 1'b1;
    tick("scan2_start");
    scan_start = 1'b0;
    wait_idx(3, 40, "wait3");
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAB;
    tick("wr_sel");
    wr_en = 1'b0;
    check_eq("wr_sel_byte", 64'(bank_flat[31:24]), 64'hAB);
    check_eq("wr_sel_hold", 64'(sel), 64'd3);
    wait_idx(5, 40, "wait5");
    async_reset();
    tick("after_rst");
    check_eq("after_rst_bank", bank_flat, 64'd0);

    scan_start = 1'b1; scan_stop = 1'b1;
    tick("start_stop");
    idle_inputs();
    check_eq("start_stop_busy", 64'(busy), 64'd0);
    tick("start_stop2");

`ifdef SCAN_SKIP_ZERO_EN
    wr_en = 1'b1;
    wr_addr = 3'd1; wr_data = 8'h22; tick("skip_fill");
    wr_addr = 3'd4; wr_data = 8'h55; tick("skip_fill");
    wr_addr = 3'd7; wr_data = 8'h88; tick("skip_fill");
    idle_inputs();
    prescale = 8'd0; loop = 1'b0; scan_start = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick("skip_scan");
      scan_start = 1'b0;
      if (step_valid) seq_q.push_back(int'(sel));
      done_cnt += int'(done);
    end
    check_eq("skip_len", 64'(seq_q.size()), 64'd3);
    if (seq_q.size() == 3) begin
      check_eq("skip_s0", 64'(seq_q[0]), 64'd1);
      check_eq("skip_s1", 64'(seq_q[1]), 64'd4);
      check_eq("skip_s2", 64'(seq_q[2]), 64'd7);
    end
    check_eq("skip_done", 64'(done_cnt), 64'd1);
    wr_en = 1'b1; wr_data = 8'h00;
    wr_addr = 3'd1; tick("skip_clr");
    wr_addr = 3'd4; tick("skip_clr");
    wr_addr = 3'd7; tick("skip_clr");
    idle_inputs();
    scan_start = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick("zero_scan");
      scan_start = 1'b0;
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check_eq("zero_done", 64'(done_cnt), 64'd1);
    check_eq("zero_busy", 64'(busy_cnt), 64'd0);
`endif

    for (int k = 0; k < 3000; k++) begin
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom);
      scan_start = ($urandom_range(0, 9) == 0);
      scan_stop  = ($urandom_range(0, 39) == 0);
      loop       = 1'($urandom);
      prescale   = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        idle_inputs();
        async_reset();
      end else begin
        tick("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/byte_bank_sequencer.md
Name: byte_bank_sequencer

Overview:
- Upstream feeder for the 8:1 8-bit output mux.
- Holds an 8-entry x 8-bit register bank and drives all eight bytes in parallel onto the mux data inputs.
- Also generates the mux select: a programmable-dwell scan sequencer with start/stop control and done signalling.
- Lets the top level step through the stored bytes on the output pins with no external sequencing logic.

Parameters:
- PRESCALE_W, 8: width of the dwell prescale input. Each index is held for prescale+1 clock cycles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  bank write strobe.
- wr_addr  input  3  bank entry to write.
- wr_data  input  8  write data.
- scan_start  input  1  start scan (level sampled each cycle; only acted on in IDLE).
- scan_stop  input  1  abort scan.
- loop  input  1  1 = continuous scan, 0 = single pass. Sampled at each wrap decision.
- prescale  input  PRESCALE_W  dwell minus one. Captured when the scan starts.
- bank_flat  output  64  entry i on bits [8i+7:8i]; feeds mux data0..data7.
- sel  output  3  mux select.
- step_valid  output  1  one-cycle pulse in the cycle sel takes a new scan value.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (async assert, sync release): bank all 0x00, sel=0, step_valid=0, busy=0, done=0, dwell counter=0, state=IDLE.
- Writes: wr_en at edge t updates entry wr_addr. The new value is visible on bank_flat after edge t, in any state. Writing the currently selected entry mid-scan is legal; the mux output changes immediately with no sel change.
- States: IDLE, SCAN, DONE.
- IDLE:
  - scan_start=1 and scan_stop=0 -> SCAN.
  - Same edge: sel<=0, step_valid<=1, dwell counter<=prescale (latched copy), busy<=1.
- SCAN: dwell counter decrements each cycle. When the counter is 0 at an edge:
  - sel<7: sel<=sel+1, counter<=latched prescale, step_valid pulse.
  - sel=7, loop=1: sel<=0, counter reload, step_valid pulse and done pulse in the same cycle; stay in SCAN.
  - sel=7, loop=0: -> DONE. done<=1, busy<=0, sel stays 7, no step_valid.
- DONE: unconditionally -> IDLE next edge; done returns to 0.
- Dwell: each index is held exactly prescale+1 cycles. prescale=0 steps every cycle. Changes to prescale mid-scan are ignored until the next start.
- scan_stop in SCAN (wins over a step on the same edge): -> IDLE, busy<=0, sel holds its current value, no done, no step_valid.
- scan_stop in IDLE or DONE: no effect.
- scan_start and scan_stop high together in IDLE: stays IDLE.
- scan_start while in SCAN or DONE: ignored.
- Reset mid-scan: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SCAN_SKIP_ZERO_EN.
- Defined:
  - Sequencer visits only entries whose byte is nonzero, evaluated at each step edge against the current bank contents.
  - Start selects the lowest nonzero index. Each step selects the lowest nonzero index greater than sel; if none, the wrap/end rules above apply (loop=1 wraps to the lowest nonzero index).
  - All-zero bank on start: go directly IDLE -> DONE. done pulses, busy stays 0, sel=0, no step_valid.
  - All-zero bank at a loop wrap: -> DONE.
- Undefined: all 8 indices are visited in order; byte values never affect sequencing.

Test Plan:
- Reset then write entries 0..7 = 0x10..0x17 -> bank_flat = 0x1716151413121110; sel=0, busy=0, done=0.
- prescale=2, loop=0, pulse scan_start -> sel runs 0..7, each held 3 cycles, 8 step_valid pulses. Then done pulses 1 cycle, busy falls at done, sel stays 7, state returns to IDLE.
- prescale=0, loop=1 -> sel increments every cycle. done pulses together with step_valid each time sel wraps 7->0. Assert scan_stop at sel=4 -> sel holds 4, busy=0, no done.
- During scan with sel=3, write entry 3 = 0xAB -> bank_flat[31:24]=0xAB the next cycle while sel stays 3. Start and stop asserted together in IDLE -> no busy.
- Assert rst_n low mid-scan (sel=5) -> outputs and bank clear asynchronously with no done pulse; after release, state is IDLE.
- SCAN_SKIP_ZERO_EN: bank = {0,0x22,0,0,0x55,0,0,0x88}, prescale=0, loop=0 -> sel sequence 1,4,7, then done. All-zero bank -> done pulse with busy never high.
